// File: rtl/router_pkg.sv
// router_pkg: types and helpers shared by the router and its input arbiter.
package router_pkg;
  localparam int P_NBITS = 32;
  typedef logic [P_NBITS-1:0] msg_t;
  function automatic int SRC_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin pick of the first request at or after ptr.
module rr_grant
  import router_pkg::*;
#(
  parameter int p_ninputs = 4
) (
  input  logic [p_ninputs-1:0]           req_i,
  input  logic [SRC_W(p_ninputs)-1:0]    ptr_i,
  output logic [p_ninputs-1:0]           grant_o,
  output logic [SRC_W(p_ninputs)-1:0]    grant_idx_o
);
  localparam int SW = SRC_W(p_ninputs);
  // scan farthest-first so the closest request to ptr overwrites the rest
  always_comb begin
    grant_o = '0;
    grant_idx_o = '0;
    for (int k = p_ninputs - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % p_ninputs]) begin
        grant_o = '0;
        grant_o[(int'(ptr_i) + k) % p_ninputs] = 1'b1;
        grant_idx_o = SW'((int'(ptr_i) + k) % p_ninputs);
      end
  end
endmodule

// File: rtl/router_input_arbiter.sv
// router_input_arbiter: round-robin share of the router input with a one-entry
// output register that drains and refills in the same cycle.
module router_input_arbiter
  import router_pkg::*;
#(
  parameter int p_nbits   = P_NBITS,
  parameter int p_ninputs = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [p_ninputs-1:0]          recv_val_i,
  input  logic [p_nbits-1:0]            recv_msg_i [p_ninputs],
  output logic [p_ninputs-1:0]          recv_rdy_o,
  output logic                          send_val_o,
  output logic [p_nbits-1:0]            send_msg_o,
  input  logic                          send_rdy_i,
  output logic [SRC_W(p_ninputs)-1:0]   send_src_o
);
  localparam int SW = SRC_W(p_ninputs);
  logic               full_q, full_d;
  logic [p_nbits-1:0] msg_q, msg_d;
  logic [SW-1:0]      src_q, src_d, ptr_q, ptr_d, gidx;
  logic [p_ninputs-1:0] grant;
  logic               can_accept, acc;
  rr_grant #(.p_ninputs(p_ninputs)) u_grant (
    .req_i      (recv_val_i),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .grant_idx_o(gidx)
  );
  assign can_accept = !full_q | send_rdy_i;
  // gate with rst_ni so nothing is acknowledged while reset holds full_q low
  assign recv_rdy_o = (can_accept & rst_ni) ? grant : '0;
  assign acc = can_accept & (|recv_val_i);
  assign send_val_o = full_q;
  assign send_msg_o = msg_q;
  assign send_src_o = src_q;
  always_comb begin
    full_d = acc | (full_q & !send_rdy_i);
    msg_d = acc ? recv_msg_i[gidx] : msg_q;
    src_d = acc ? gidx : src_q;
    ptr_d = !acc ? ptr_q : (gidx == SW'(p_ninputs - 1)) ? '0 : gidx + 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      full_q <= 1'b0;
      msg_q <= '0;
      src_q <= '0;
      ptr_q <= '0;
    end else begin
      full_q <= full_d;
      msg_q <= msg_d;
      src_q <= src_d;
      ptr_q <= ptr_d;
    end
endmodule

// File: tb/tb_router_input_arbiter.sv
// tb_router_input_arbiter: scenario tasks checked against a queue-free
// behavioural model of the round-robin buffer.
module tb_router_input_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  val = '0;
  logic [31:0] msg [4];
  logic [3:0]  rdy_o;
  logic        send_val, send_rdy = 1'b0;
  logic [31:0] send_msg;
  logic [1:0]  send_src;
  int checks = 0, errors = 0;
  int m_full = 0, m_src = 0, m_ptr = 0;
  logic [31:0] m_msg = '0;

  router_input_arbiter #(.p_nbits(32), .p_ninputs(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .recv_val_i(val), .recv_msg_i(msg),
    .recv_rdy_o(rdy_o), .send_val_o(send_val), .send_msg_o(send_msg),
    .send_rdy_i(send_rdy), .send_src_o(send_src)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_rdy();
    int g = pick(val, m_ptr);
    if (!rst_n || g < 0 || (m_full != 0 && !send_rdy)) return 4'b0;
    return 4'b1 << g;
  endfunction

  task automatic model_reset();
    m_full = 0; m_src = 0; m_ptr = 0; m_msg = '0;
  endtask

  task automatic tick();
    int g;
    @(posedge clk);
    g = pick(val, m_ptr);
    if (rst_n) begin
      if ((m_full == 0 || send_rdy) && g >= 0) begin
        m_full = 1; m_msg = msg[g]; m_src = g; m_ptr = (g + 1) % 4;
      end else if (m_full != 0 && send_rdy) m_full = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    val = '0; send_rdy = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; val = 4'hF; send_rdy = 1'b1;
    for (int i = 0; i < 4; i++) msg[i] = 32'h1000 + i;
    repeat (2) tick();
    checks += 4;
    if (send_val !== 1'b0) begin errors++; $display("FAIL reset_val got %b want 0", send_val); end
    if (rdy_o !== 4'b0) begin errors++; $display("FAIL reset_rdy got %b want 0000", rdy_o); end
    if (send_msg !== 32'h0) begin errors++; $display("FAIL reset_msg got %h want 0", send_msg); end
    if (send_src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", send_src); end
    rst_n = 1'b1; model_reset(); #1;
    checks++;
    if (rdy_o !== 4'b0001) begin errors++; $display("FAIL reset_first_rdy got %b want 0001", rdy_o); end
    tick();
    checks++;
    if (send_src !== 2'd0 || send_val !== 1'b1) begin errors++; $display("FAIL reset_first_src got %0d/%b want 0/1", send_src, send_val); end
  endtask

  task automatic test_single();
    do_reset();
    val = 4'b0100; msg[2] = 32'h8000_00AA; send_rdy = 1'b1; #1;
    checks++;
    if (rdy_o !== 4'b0100) begin errors++; $display("FAIL single_rdy got %b want 0100", rdy_o); end
    tick(); val = '0;
    checks += 2;
    if (send_val !== 1'b1 || send_msg !== 32'h8000_00AA || send_src !== 2'd2) begin
      errors++; $display("FAIL single_out got %b/%h/%0d want 1/800000aa/2", send_val, send_msg, send_src);
    end
    if (dut.ptr_q !== 2'd3) begin errors++; $display("FAIL single_ptr got %0d want 3", dut.ptr_q); end
  endtask

  task automatic test_rotation();
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    val = 4'hF; send_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) msg[j] = $urandom;
      #1;
      checks++;
      if (rdy_o !== exp_rdy()) begin errors++; $display("FAIL rot_rdy[%0d] got %b want %b", i, rdy_o, exp_rdy()); end
      tick();
      checks++;
      if (send_val !== 1'b1 || send_src !== 2'(seq[i]) || send_msg !== m_msg) begin
        errors++; $display("FAIL rot_out[%0d] got %b/%0d/%h want 1/%0d/%h", i, send_val, send_src, send_msg, seq[i], m_msg);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] held;
    do_reset();
    val = 4'b0010; msg[1] = $urandom; held = msg[1]; send_rdy = 1'b1;
    tick();
    val = 4'hF; send_rdy = 1'b0;
    for (int j = 0; j < 4; j++) msg[j] = $urandom;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 3;
      if (rdy_o !== 4'b0) begin errors++; $display("FAIL bp_rdy[%0d] got %b want 0000", i, rdy_o); end
      if (send_msg !== held || send_src !== 2'd1 || send_val !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got %h/%0d want %h/1", i, send_msg, send_src, held);
      end
      if (dut.ptr_q !== 2'd2) begin errors++; $display("FAIL bp_ptr[%0d] got %0d want 2", i, dut.ptr_q); end
      tick();
    end
    send_rdy = 1'b1; #1;
    checks++;
    if (rdy_o !== 4'b0100) begin errors++; $display("FAIL bp_refill_rdy got %b want 0100", rdy_o); end
    tick();
    checks++;
    if (send_val !== 1'b1 || send_src !== 2'd2 || send_msg !== msg[2]) begin
      errors++; $display("FAIL bp_refill got %b/%0d/%h want 1/2/%h", send_val, send_src, send_msg, msg[2]);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    send_rdy = 1'b1; val = 4'b0001; msg[0] = $urandom; msg[3] = $urandom;
    tick();
    val = 4'b1001; #1;
    checks++;
    if (rdy_o !== 4'b1000) begin errors++; $display("FAIL fair_rdy3 got %b want 1000", rdy_o); end
    tick();
    checks += 2;
    if (send_src !== 2'd3) begin errors++; $display("FAIL fair_src3 got %0d want 3", send_src); end
    if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL fair_ptr got %0d want 0", dut.ptr_q); end
    checks++;
    if (rdy_o !== 4'b0001) begin errors++; $display("FAIL fair_rdy0 got %b want 0001", rdy_o); end
    tick();
    checks++;
    if (send_src !== 2'd0) begin errors++; $display("FAIL fair_src0 got %0d want 0", send_src); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    send_rdy = 1'b1; val = 4'b1000; msg[3] = 32'hDEAD_BEEF;
    tick();
    send_rdy = 1'b0; val = '0;
    repeat (2) tick();
    #2 rst_n = 1'b0; #1;
    checks += 2;
    if (send_val !== 1'b0) begin errors++; $display("FAIL stall_rst_val got %b want 0", send_val); end
    if (rdy_o !== 4'b0) begin errors++; $display("FAIL stall_rst_rdy got %b want 0000", rdy_o); end
    @(posedge clk); #1;
    rst_n = 1'b1; model_reset(); send_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (send_val !== 1'b0 || send_msg === 32'hDEAD_BEEF) begin
        errors++; $display("FAIL stall_old[%0d] got %b/%h want 0/not deadbeef", i, send_val, send_msg);
      end
    end
    checks++;
    if (dut.ptr_q !== 2'd0) begin errors++; $display("FAIL stall_ptr got %0d want 0", dut.ptr_q); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      val = 4'($urandom_range(0, 15));
      send_rdy = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < 4; j++) msg[j] = $urandom;
      #1;
      checks++;
      if (rdy_o !== exp_rdy()) begin errors++; $display("FAIL rand_rdy[%0d] got %b want %b", i, rdy_o, exp_rdy()); end
      tick();
      checks++;
      if (send_val !== (m_full != 0) || (m_full != 0 && (send_msg !== m_msg || send_src !== 2'(m_src)))) begin
        errors++; $display("FAIL rand_out[%0d] got %b/%h/%0d want %0d/%h/%0d", i, send_val, send_msg, send_src, m_full, m_msg, m_src);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) msg[i] = '0;
    test_reset();
    test_single();
    test_rotation();
    test_back_pressure();
    test_fairness();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_input_arbiter.md
# router_input_arbiter

Round-robin arbiter that shares the single val/rdy input of the address-demux router among `p_ninputs` requesters. Each cycle it selects one valid requester, captures its message into a one-entry output register, and presents it to the router together with the source index. The message passes through unmodified; destination bits stay in the MSBs for the router to decode. Priority rotates so that no requester starves while the router back-pressures.

## Interface
- `p_nbits`, 32, message width. Must equal the router's `p_nbits`.
- `p_ninputs`, 4, number of requesters. Must be ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `recv_val[0:p_ninputs-1]`  in  1 each  requester message valid.
- `recv_msg[0:p_ninputs-1]`  in  p_nbits each  requester message.
- `recv_rdy[0:p_ninputs-1]`  out  1 each  requester accepted this cycle.
- `send_val`  out  1  buffered message valid; drives router `valid`.
- `send_msg`  out  p_nbits  buffered message; drives router `message_in`.
- `send_rdy`  in  1  router `ready_out`.
- `send_src`  out  $clog2(p_ninputs)  index of the requester that supplied `send_msg`.

## Operation
- State:
  - `full`: the output register holds a message.
  - `msg_q`, `src_q`: the buffered message and its source index.
  - `ptr`: highest-priority index, range 0..p_ninputs-1.
- `send_val = full`, `send_msg = msg_q`, `send_src = src_q`.
- `can_accept = !full | send_rdy`. This allows full throughput: the buffer drains and refills in the same cycle.
- Grant (combinational): scan indices `ptr, ptr+1, …` (mod p_ninputs). The first `i` with `recv_val[i]=1` is granted. At most one grant per cycle.
- `recv_rdy[i] = can_accept & grant[i]`. It is 0 for every non-granted input and for all inputs when `!can_accept`.
- On an accept (`recv_val[i] & recv_rdy[i]`):
  - `msg_q <= recv_msg[i]`, `src_q <= i`, `full <= 1`.
  - `ptr <= (i+1) mod p_ninputs`; wraps from p_ninputs-1 to 0.
- Drain without accept (`full & send_rdy` and no grant): `full <= 0`. `msg_q`/`src_q` hold their values and are don't-care.
- Stall (`full & !send_rdy`): all state holds. `send_msg` stays stable while `send_val=1`.
- `ptr` changes only on an accept. It does not advance on idle or stalled cycles.
- Requesters must not make `recv_val` depend on `recv_rdy`. A requester may drop `recv_val` before it is accepted; the arbiter stores nothing for it.

## Timing
- Reset (async assert, sync deassert at the edge): `full=0`, `send_val=0`, `send_msg=0`, `send_src=0`, `ptr=0`. All `recv_rdy` are 0 while `reset=0`.
- Reset asserted mid-operation discards the buffered message, even if it was never handed to the router.
- Latency: a message accepted at edge N is visible on `send_*` after edge N and can be consumed at edge N+1.
- Throughput: one message per cycle sustained while `send_rdy=1`.
- Combinational paths:
  - `recv_val` → `recv_rdy` (through grant).
  - `send_rdy` → `recv_rdy`.
  - There is no path from `recv_*` to `send_*`.
- Simultaneous drain and accept in one cycle: the new message replaces the old one and `full` stays 1.

## Structure
- Shared package `router_pkg`:
  - `SRC_W = $clog2(p_ninputs)` helper function.
  - Message-type typedef shared with the router, so both blocks agree on `p_nbits`.
- Sub-module `rr_grant`:
  - Parameter `p_ninputs`.
  - Inputs `req[p_ninputs]` and `ptr`.
  - Outputs one-hot `grant` and encoded `grant_idx`.
  - Purely combinational.
- The top level holds the output register, `full`, `ptr`, and the val/rdy glue.

## Test plan
All scenarios use p_nbits=32, p_ninputs=4.
- Reset: hold `reset=0` while driving all `recv_val=1` → `send_val=0`, all `recv_rdy=0`. After release, the first accept is from input 0.
- Single requester: `recv_val[2]=1`, `msg=0x8000_00AA`, `send_rdy=1` → `recv_rdy[2]=1` in cycle 0. Next cycle `send_val=1`, `send_msg=0x8000_00AA`, `send_src=2`, `ptr=3`.
- Rotation with wrap-around: all four inputs valid continuously, `send_rdy=1` → `send_src` sequence is 0,1,2,3,0,1 with one message per cycle.
- Back-pressure: fill the buffer from input 1, hold `send_rdy=0` for 3 cycles → `send_msg`/`send_src` stable, all `recv_rdy=0`, `ptr` stays 2. Raise `send_rdy` → drain and refill from input 2 in the same cycle.
- Fairness skip: only inputs 0 and 3 valid, `ptr=1` → input 3 is granted first and `ptr` wraps to 0. Next grant is input 0.
- Reset mid-stall: buffer full with `send_rdy=0`, assert `reset` asynchronously between edges → `send_val` drops to 0 immediately. After release `ptr=0` and the old message never appears.
